// File: rtl/spi_wb_pkg.sv
// Shared types and constants for the SPI-slave to Wishbone bridge.
package spi_wb_pkg;

   typedef enum logic [1:0] {
      F_IDLE,
      F_CMD,
      F_ADDR,
      F_DATA
   } frame_state_t;

   typedef enum logic {
      WB_IDLE,
      WB_BUSY
   } wb_state_t;

   localparam int         CMD_READ_BIT = 7;
   localparam logic [7:0] DUMMY_BYTE   = 8'h00;
   localparam logic [7:0] ERR_BYTE     = 8'hFF;

endpackage

// File: rtl/spi_slave_wb_bridge_if.sv
// 8-bit Wishbone register bus as driven by the serial-host bridges.
interface spi_slave_wb_bridge_if;

   logic [7:0] wb_adr_o;
   logic [7:0] wb_dat_o;
   logic [7:0] wb_dat_i;
   logic       wb_we_o;
   logic       wb_cyc_o;
   logic       wb_stb_o;
   logic       wb_ack_i;
   logic       wb_err_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i, wb_err_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i, wb_err_i
   );

endinterface

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave byte engine: pad synchronizers, SCK edge detect,
// bit counter, rx/tx shift registers and MISO drive.
module spi_slave_shifter
   import spi_wb_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       ss_n,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   output logic       frame_start,
   output logic       active,
   output logic       byte_done,
   output logic [7:0] rx_byte,
   input  logic       tx_load,
   input  logic [7:0] tx_byte
);

   logic [SYNC_STAGES-1:0] sck_sync, ss_n_sync, mosi_sync;
   logic sck_s, ss_n_s, mosi_s;
   logic sck_d, ss_n_d;
   logic sck_rise, sck_fall;
   logic sel;
   logic [2:0] bit_cnt;
   logic [6:0] rx_sr;
   logic [7:0] tx_sr;

   // Select syncs reset to "asserted" so a frame held low across reset
   // is not mistaken for a new one; a high level must be seen first.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync  <= '0;
         ss_n_sync <= '0;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         ss_n_d    <= 1'b0;
      end else begin
         sck_sync  <= (sck_sync << 1)  | SYNC_STAGES'(sck);
         ss_n_sync <= (ss_n_sync << 1) | SYNC_STAGES'(ss_n);
         mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(mosi);
         sck_d     <= sck_s;
         ss_n_d    <= ss_n_s;
      end
   end

   assign sck_s       = sck_sync[SYNC_STAGES-1];
   assign ss_n_s      = ss_n_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign sck_rise    = sck_s & ~sck_d;
   assign sck_fall    = ~sck_s & sck_d;
   assign frame_start = ss_n_d & ~ss_n_s;

   assign rx_byte   = {rx_sr, mosi_s};
   assign byte_done = sel & ~ss_n_s & sck_rise & (bit_cnt == 3'd7);

   always_ff @(posedge clk) begin
      if (rst) begin
         sel     <= 1'b0;
         bit_cnt <= 3'd0;
         rx_sr   <= '0;
         tx_sr   <= '0;
      end else if (frame_start) begin
         sel     <= 1'b1;
         bit_cnt <= 3'd0;
         rx_sr   <= '0;
         tx_sr   <= DUMMY_BYTE;
      end else if (ss_n_s) begin
         sel     <= 1'b0;
      end else if (sel) begin
         if (sck_rise) begin
            rx_sr   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
         end
         // The falling edge right after a byte boundary must not shift,
         // otherwise the freshly loaded MSB would be lost.
         if (tx_load) begin
            tx_sr <= tx_byte;
         end else if (sck_fall && bit_cnt != 3'd0) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
         end
      end
   end

   assign miso    = sel & tx_sr[7];
   assign miso_oe = sel;
   assign active  = sel;

endmodule

// File: rtl/spi_slave_wb_bridge.sv
// SPI slave to Wishbone master bridge. Optional macro SPI_WB_TIMEOUT_EN
// aborts a Wishbone cycle after WB_TIMEOUT clocks and treats it as an error.
//
// state  | meaning
// F_IDLE | not selected, waiting for ss_n to assert
// F_CMD  | receiving command byte (bit 7 = read)
// F_ADDR | receiving start address
// F_DATA | data bytes: write per byte, or read-ahead stream
// WB_IDLE| no bus cycle
// WB_BUSY| cyc/stb held until ack/err (or timeout)
module spi_slave_wb_bridge
   import spi_wb_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int WB_TIMEOUT  = 255
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic sck_i,
   input  logic ss_n_i,
   input  logic mosi_i,
   output logic miso_o,
   output logic miso_oe_o,
   output logic err_o,
   output logic ovr_o,
   spi_slave_wb_bridge_if.master wb
);

   frame_state_t f_state, f_next;
   wb_state_t    wb_state, wb_next;

   logic       frame_start, active, byte_done;
   logic [7:0] rx_byte;
   logic       tx_load;
   logic [7:0] tx_byte;

   logic       is_read;
   logic [7:0] adr_cnt;
   logic [7:0] rd_buf;
   logic       rd_valid;

   logic       req, req_we, load_late;
   logic [7:0] req_adr, req_dat;
   logic       tmo, wb_done, wb_fail;

   logic [7:0] adr_q, dat_q;
   logic       we_q;

   spi_slave_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
      .clk         (wb_clk_i),
      .rst         (wb_rst_i),
      .sck         (sck_i),
      .ss_n        (ss_n_i),
      .mosi        (mosi_i),
      .miso        (miso_o),
      .miso_oe     (miso_oe_o),
      .frame_start (frame_start),
      .active      (active),
      .byte_done   (byte_done),
      .rx_byte     (rx_byte),
      .tx_load     (tx_load),
      .tx_byte     (tx_byte)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         f_state  <= F_IDLE;
         wb_state <= WB_IDLE;
      end else begin
         f_state  <= f_next;
         wb_state <= wb_next;
      end
   end

   always_comb begin
      f_next    = f_state;
      tx_load   = 1'b0;
      tx_byte   = DUMMY_BYTE;
      req       = 1'b0;
      req_we    = 1'b0;
      req_adr   = adr_cnt;
      req_dat   = rx_byte;
      load_late = 1'b0;
      if (frame_start) begin
         f_next = F_CMD;
      end else if (!active) begin
         f_next = F_IDLE;
      end else if (byte_done) begin
         unique case (f_state)
            F_CMD: begin
               f_next  = F_ADDR;
               tx_load = 1'b1;
            end
            F_ADDR: begin
               f_next  = F_DATA;
               tx_load = 1'b1;
               req_adr = rx_byte;
               req     = is_read;
            end
            F_DATA: begin
               req    = 1'b1;
               req_we = ~is_read;
               if (is_read) begin
                  tx_load   = 1'b1;
                  tx_byte   = rd_valid ? rd_buf : ERR_BYTE;
                  load_late = ~rd_valid;
               end
            end
            default: f_next = F_IDLE;
         endcase
      end
   end

   always_comb begin
      wb_next = wb_state;
      unique case (wb_state)
         WB_IDLE: if (req) wb_next = WB_BUSY;
         WB_BUSY: if (wb_done) wb_next = WB_IDLE;
         default: wb_next = WB_IDLE;
      endcase
   end

   assign wb_fail = wb.wb_err_i | tmo;
   assign wb_done = (wb_state == WB_BUSY) & (wb.wb_ack_i | wb_fail);

`ifdef SPI_WB_TIMEOUT_EN
   localparam int TMO_W = $clog2(WB_TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         tmo_cnt <= '0;
      end else if (wb_state == WB_IDLE) begin
         tmo_cnt <= TMO_W'(WB_TIMEOUT - 1);
      end else if (tmo_cnt != '0) begin
         tmo_cnt <= tmo_cnt - TMO_W'(1);
      end
   end

   assign tmo = (wb_state == WB_BUSY) && (tmo_cnt == '0);
`else
   logic [31:0] timeout_unused;
   assign timeout_unused = 32'(WB_TIMEOUT);
   assign tmo            = 1'b0;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         is_read  <= 1'b0;
         adr_cnt  <= '0;
         rd_buf   <= '0;
         rd_valid <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         we_q     <= 1'b0;
         err_o    <= 1'b0;
         ovr_o    <= 1'b0;
      end else begin
         if (byte_done && f_state == F_CMD) is_read <= rx_byte[CMD_READ_BIT];
         // Address advances per data byte even when its request is dropped.
         if (req) begin
            adr_cnt <= req_adr + 8'd1;
         end else if (byte_done && f_state == F_ADDR) begin
            adr_cnt <= rx_byte;
         end
         if (wb_state == WB_IDLE && req) begin
            adr_q <= req_adr;
            dat_q <= req_dat;
            we_q  <= req_we;
         end
         if (tx_load && f_state == F_DATA) rd_valid <= 1'b0;
         if (wb_done && !we_q) begin
            rd_buf   <= wb_fail ? ERR_BYTE : wb.wb_dat_i;
            rd_valid <= 1'b1;
         end
         if (frame_start) begin
            rd_valid <= 1'b0;
            err_o    <= 1'b0;
            ovr_o    <= 1'b0;
         end
         if (wb_done && wb_fail) err_o <= 1'b1;
         if (load_late || (req && wb_state == WB_BUSY)) ovr_o <= 1'b1;
      end
   end

   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_cyc_o = (wb_state == WB_BUSY);
   assign wb.wb_stb_o = (wb_state == WB_BUSY);

endmodule

// File: tb/tb_spi_slave_wb_bridge.sv
// Directed bench for spi_slave_wb_bridge: SPI master at f_clk/8 plus a
// Wishbone slave model with programmable wait states and error address.
module tb_spi_slave_wb_bridge;

   logic clk = 1'b0;
   logic wb_rst = 1'b1;
   logic sck = 1'b0;
   logic ss_n = 1'b1;
   logic mosi = 1'b0;
   logic miso, miso_oe, err_o, ovr_o;

   spi_slave_wb_bridge_if bus ();

   spi_slave_wb_bridge #(.SYNC_STAGES(2), .WB_TIMEOUT(16)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (wb_rst),
      .sck_i     (sck),
      .ss_n_i    (ss_n),
      .mosi_i    (mosi),
      .miso_o    (miso),
      .miso_oe_o (miso_oe),
      .err_o     (err_o),
      .ovr_o     (ovr_o),
      .wb        (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  rd_mem [256];
   int          hold_clks = 0;
   int          wait_cnt = 0;
   logic        err_en = 1'b0;
   logic [7:0]  err_adr = 8'h00;
   logic        term;
   logic [15:0] wr_log [64];
   int          wr_cnt = 0;
   int          cyc_run = 0;
   int          last_cyc_len = 0;

   assign term = bus.wb_cyc_o & bus.wb_stb_o & (wait_cnt >= hold_clks);
   assign bus.wb_ack_i = term & ~(err_en & (bus.wb_adr_o == err_adr));
   assign bus.wb_err_i = term & err_en & (bus.wb_adr_o == err_adr);
   assign bus.wb_dat_i = rd_mem[bus.wb_adr_o];

   always @(posedge clk) begin
      if (bus.wb_cyc_o && !term) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (bus.wb_ack_i && bus.wb_we_o && wr_cnt < 64) begin
         wr_log[wr_cnt] <= {bus.wb_adr_o, bus.wb_dat_o};
         wr_cnt <= wr_cnt + 1;
      end
      if (bus.wb_cyc_o) cyc_run <= cyc_run + 1;
      else if (cyc_run != 0) begin
         last_cyc_len <= cyc_run;
         cyc_run <= 0;
      end
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   logic [7:0] tx_buf [8];
   logic [7:0] rx_buf [8];
   logic       oe_seen, err_at_start;

   task automatic spi_bits(input logic [7:0] txb, input int nbits, output logic [7:0] rxb);
      rxb = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         mosi = txb[i];
         repeat (4) @(negedge clk);
         rxb[i] = miso;
         sck = 1'b1;
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic spi_frame(input int nbytes, input int cut);
      int nb;
      logic [7:0] r;
      ss_n = 1'b0;
      repeat (4) @(negedge clk);
      oe_seen = miso_oe;
      err_at_start = err_o;
      for (int b = 0; b < nbytes; b++) begin
         nb = (cut != 0 && b == nbytes - 1) ? cut : 8;
         spi_bits(tx_buf[b], nb, r);
         rx_buf[b] = r;
      end
      repeat (4) @(negedge clk);
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic wait_bus_idle(input string tag);
      for (int k = 0; k < 400 && bus.wb_cyc_o; k++) @(negedge clk);
      chk(tag, bus.wb_cyc_o, 0);
      repeat (2) @(negedge clk);
   endtask

   int base;
   logic [7:0] r;

   initial begin
      for (int i = 0; i < 256; i++) rd_mem[i] = 8'(i) ^ 8'h5A;
      rd_mem[8'h20] = 8'h11;
      rd_mem[8'h21] = 8'h22;

      repeat (4) @(negedge clk);
      chk("rst_oe", miso_oe, 0);
      chk("rst_bus", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o}, 0);
      chk("rst_flags", {miso, err_o, ovr_o}, 0);
      wb_rst = 1'b0;
      repeat (6) @(negedge clk);

      // write frame, zero-wait slave
      base = wr_cnt;
      tx_buf[0] = 8'h00; tx_buf[1] = 8'h10; tx_buf[2] = 8'hA5; tx_buf[3] = 8'h5A;
      spi_frame(4, 0);
      chk("wr_oe_in_frame", oe_seen, 1);
      chk("wr_oe_after", miso_oe, 0);
      chk("wr_count", wr_cnt - base, 2);
      chk("wr_first", wr_log[base], 16'h10A5);
      chk("wr_second", wr_log[base+1], 16'h115A);
      chk("wr_flags", {err_o, ovr_o}, 0);

      // read frame with read-ahead
      tx_buf[0] = 8'h80; tx_buf[1] = 8'h20; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00; tx_buf[4] = 8'h00;
      spi_frame(5, 0);
      chk("rd_b0", rx_buf[0], 8'h00);
      chk("rd_b1", rx_buf[1], 8'h00);
      chk("rd_b2", rx_buf[2], 8'h00);
      chk("rd_b3", rx_buf[3], 8'h11);
      chk("rd_b4", rx_buf[4], 8'h22);
      chk("rd_flags", {err_o, ovr_o}, 0);
      wait_bus_idle("rd_idle");

      // address wrap
      base = wr_cnt;
      tx_buf[0] = 8'h00; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h01; tx_buf[3] = 8'h02;
      spi_frame(4, 0);
      chk("wrap_count", wr_cnt - base, 2);
      chk("wrap_first", wr_log[base], 16'hFF01);
      chk("wrap_second", wr_log[base+1], 16'h0002);

      // error termination on a read
      err_en = 1'b1; err_adr = 8'h30;
      tx_buf[0] = 8'h80; tx_buf[1] = 8'h30; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
      spi_frame(4, 0);
      chk("err_b3", rx_buf[3], 8'hFF);
      chk("err_flag", err_o, 1);
      chk("err_ovr", ovr_o, 0);
      wait_bus_idle("err_idle");
      err_en = 1'b0;
      repeat (20) @(negedge clk);
      chk("err_held", err_o, 1);

      // slave withholds ack past the next byte boundary
      hold_clks = 100;
      tx_buf[0] = 8'h80; tx_buf[1] = 8'h40; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
      spi_frame(4, 0);
      chk("late_err_cleared", err_at_start, 0);
      chk("late_b2", rx_buf[2], 8'h00);
      chk("late_b3", rx_buf[3], 8'hFF);
      wait_bus_idle("late_idle");
`ifdef SPI_WB_TIMEOUT_EN
      chk("late_ovr", ovr_o, 0);
      chk("late_err", err_o, 1);
      chk("tmo_len", last_cyc_len, 16);
`else
      chk("late_ovr", ovr_o, 1);
      chk("late_err", err_o, 0);
      chk("hold_len", last_cyc_len, 101);
`endif
      hold_clks = 0;

      // ss_n released after 4 bits of a data byte
      base = wr_cnt;
      tx_buf[0] = 8'h00; tx_buf[1] = 8'h50; tx_buf[2] = 8'h77; tx_buf[3] = 8'hC3;
      spi_frame(4, 4);
      wait_bus_idle("part_idle");
      chk("part_count", wr_cnt - base, 1);
      chk("part_write", wr_log[base], 16'h5077);

      // reset pulsed while a write cycle is in flight, ss_n held low
      hold_clks = 1000;
      base = wr_cnt;
      ss_n = 1'b0;
      repeat (4) @(negedge clk);
      spi_bits(8'h00, 8, r);
      spi_bits(8'h60, 8, r);
      spi_bits(8'h33, 8, r);
      repeat (4) @(negedge clk);
      chk("rst_cyc_up", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 3'b111);
      wb_rst = 1'b1;
      @(negedge clk);
      chk("rst_all_zero", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o,
                           bus.wb_dat_o, miso, miso_oe, err_o, ovr_o}, 0);
      wb_rst = 1'b0;
      hold_clks = 0;
      spi_bits(8'h00, 8, r);
      spi_bits(8'h61, 8, r);
      spi_bits(8'h44, 8, r);
      repeat (8) @(negedge clk);
      chk("rst_no_resume", wr_cnt - base, 0);
      chk("rst_oe_low", miso_oe, 0);
      ss_n = 1'b1;
      repeat (8) @(negedge clk);
      tx_buf[0] = 8'h00; tx_buf[1] = 8'h70; tx_buf[2] = 8'h99;
      spi_frame(3, 0);
      wait_bus_idle("rec_idle");
      chk("rec_count", wr_cnt - base, 1);
      chk("rec_write", wr_log[base], 16'h7099);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
